// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and single memory port of the arbiter.
// master is the requester/memory side; slave is the arbiter itself.
interface mem_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
);

  logic                if_req;
  logic [ADDRSIZE-1:0] if_addr;
  logic                if_gnt;
  logic                if_rvalid;
  logic [WIDTH-1:0]    if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDRSIZE-1:0] d_addr;
  logic [WIDTH-1:0]    d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [WIDTH-1:0]    d_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rdata;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data access.
// Data normally wins; fetch is forced through after MAXWAIT consecutive losses.
module mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int MAXWAIT  = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q,     state_d;
  logic [CW-1:0]       waitCnt_q,   waitCnt_d;
  logic                memEn_q,     memEn_d;
  logic                memWe_q,     memWe_d;
  logic [ADDRSIZE-1:0] memAddr_q,   memAddr_d;
  logic [WIDTH-1:0]    memWdata_q,  memWdata_d;
  logic                ifGnt_q,     ifGnt_d;
  logic                dGnt_q,      dGnt_d;
  logic                ifRvalid_q,  ifRvalid_d;
  logic                dRvalid_q,   dRvalid_d;
  logic [WIDTH-1:0]    ifRdata_q,   ifRdata_d;
  logic [WIDTH-1:0]    dRdata_q,    dRdata_d;
  logic                fetchWins;
  logic                starved;

  assign starved = (waitCnt_q == CW'(MAXWAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifGnt_q    <= 1'b0;
      dGnt_q     <= 1'b0;
      ifRvalid_q <= 1'b0;
      dRvalid_q  <= 1'b0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ifGnt_q    <= ifGnt_d;
      dGnt_q     <= dGnt_d;
      ifRvalid_q <= ifRvalid_d;
      dRvalid_q  <= dRvalid_d;
      ifRdata_q  <= ifRdata_d;
      dRdata_q   <= dRdata_d;
    end
  end

  // Memory command and grant are registered at the decision edge, so they
  // appear during ACCESS; the response pulse is registered on leaving ACCESS.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    memEn_d    = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = '0;
    memWdata_d = '0;
    ifGnt_d    = 1'b0;
    dGnt_d     = 1'b0;
    ifRvalid_d = 1'b0;
    dRvalid_d  = 1'b0;
    fetchWins  = 1'b0;
    ifRdata_d  = ifRvalid_q ? bus.mem_rdata : ifRdata_q;
    dRdata_d   = dRvalid_q  ? bus.mem_rdata : dRdata_q;

    unique case (state_q)
      IDLE, RESP: begin
        if (bus.if_req || bus.d_req) begin
          state_d   = ACCESS;
          memEn_d   = 1'b1;
          fetchWins = bus.if_req && (!bus.d_req || starved);
          if (fetchWins) begin
            memAddr_d = bus.if_addr;
            ifGnt_d   = 1'b1;
            waitCnt_d = '0;
          end else begin
            memWe_d    = bus.d_we;
            memAddr_d  = bus.d_addr;
            memWdata_d = bus.d_wdata;
            dGnt_d     = 1'b1;
            if (bus.if_req && !starved) begin
              waitCnt_d = waitCnt_q + CW'(1);
            end
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        state_d    = RESP;
        ifRvalid_d = ifGnt_q;
        dRvalid_d  = dGnt_q && !memWe_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.if_gnt    = ifGnt_q;
  assign bus.d_gnt     = dGnt_q;
  assign bus.if_rvalid = ifRvalid_q;
  assign bus.d_rvalid  = dRvalid_q;

  // Read data arrives straight from memory during RESP and is held afterwards.
  assign bus.if_rdata  = ifRvalid_q ? bus.mem_rdata : ifRdata_q;
  assign bus.d_rdata   = dRvalid_q  ? bus.mem_rdata : dRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: bench-side memory, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int A  = 12;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.WIDTH(W), .ADDRSIZE(A)) bus ();

  mem_arbiter #(.WIDTH(W), .ADDRSIZE(A), .MAXWAIT(MW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Unwritten locations hold a recognisable pattern derived from the address.
  function automatic logic [W-1:0] initWord(input logic [A-1:0] a);
    if (a == 12'h005) return 32'h2000_1003;
    return {20'hA5A50, a};
  endfunction

  // Memory attached to the arbiter: synchronous, one-cycle read latency.
  logic [W-1:0] benchMem [4096];
  bit           benchWritten [4096];
  logic [W-1:0] memRdataQ = '0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        benchMem[bus.mem_addr]     <= bus.mem_wdata;
        benchWritten[bus.mem_addr] <= 1'b1;
      end else begin
        memRdataQ <= benchWritten[bus.mem_addr] ? benchMem[bus.mem_addr]
                                                : initWord(bus.mem_addr);
      end
    end
  end

  assign bus.mem_rdata = memRdataQ;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a decision can happen in any cycle that is not the one
  // right after a decision; each access occupies one cycle, a read returns one
  // cycle later with the word the memory held when the access was decided.
  logic [W-1:0] modelMem [4096];
  bit           modelWritten [4096];
  int           starve;
  logic         accV, accFetch, accWe;
  logic [A-1:0] accAddr;
  logic [W-1:0] accWdata, accRdata;
  logic         rspIf, rspD;
  logic [W-1:0] rspData, holdIf, holdD;
  logic         pickFetch;
  logic [A-1:0] pickAddr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= 0;
      accV <= 1'b0; accFetch <= 1'b0; accWe <= 1'b0;
      accAddr <= '0; accWdata <= '0; accRdata <= '0;
      rspIf <= 1'b0; rspD <= 1'b0; rspData <= '0;
      holdIf <= '0; holdD <= '0;
    end else begin
      rspIf   <= accV && accFetch;
      rspD    <= accV && !accFetch && !accWe;
      rspData <= accRdata;
      if (rspIf) holdIf <= rspData;
      if (rspD)  holdD  <= rspData;
      accV <= 1'b0;
      if (!accV && (bus.if_req || bus.d_req)) begin
        pickFetch = bus.if_req && (!bus.d_req || starve >= MW);
        pickAddr  = pickFetch ? bus.if_addr : bus.d_addr;
        accV     <= 1'b1;
        accFetch <= pickFetch;
        accWe    <= pickFetch ? 1'b0 : bus.d_we;
        accAddr  <= pickAddr;
        accWdata <= bus.d_wdata;
        accRdata <= modelWritten[pickAddr] ? modelMem[pickAddr] : initWord(pickAddr);
        if (!pickFetch && bus.d_we) begin
          modelMem[pickAddr]     <= bus.d_wdata;
          modelWritten[pickAddr] <= 1'b1;
        end
        if (pickFetch)        starve <= 0;
        else if (bus.if_req)  starve <= (starve + 1 > MW) ? MW : starve + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("if_gnt",    W'(bus.if_gnt),    W'(accV && accFetch));
    checkOutput("d_gnt",     W'(bus.d_gnt),     W'(accV && !accFetch));
    checkOutput("mem_en",    W'(bus.mem_en),    W'(accV));
    checkOutput("if_rvalid", W'(bus.if_rvalid), W'(rspIf));
    checkOutput("d_rvalid",  W'(bus.d_rvalid),  W'(rspD));
    checkOutput("if_rdata",  bus.if_rdata,      rspIf ? rspData : holdIf);
    checkOutput("d_rdata",   bus.d_rdata,       rspD  ? rspData : holdD);
    checkOutput("gnt_onehot",    W'(bus.if_gnt & bus.d_gnt),       '0);
    checkOutput("rvalid_onehot", W'(bus.if_rvalid & bus.d_rvalid), '0);
    if (accV) begin
      checkOutput("mem_we",   W'(bus.mem_we),   W'(accWe));
      checkOutput("mem_addr", W'(bus.mem_addr), W'(accAddr));
      if (accWe) checkOutput("mem_wdata", bus.mem_wdata, accWdata);
    end
  end

  task automatic applyStimulus(input logic ifReq, input logic [A-1:0] ifAddr,
                               input logic dReq, input logic dWe,
                               input logic [A-1:0] dAddr, input logic [W-1:0] dWdata);
    bus.if_req  = ifReq;
    bus.if_addr = ifAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_if_gnt"},    W'(bus.if_gnt),    '0);
    checkOutput({tag, "_d_gnt"},     W'(bus.d_gnt),     '0);
    checkOutput({tag, "_mem_en"},    W'(bus.mem_en),    '0);
    checkOutput({tag, "_mem_we"},    W'(bus.mem_we),    '0);
    checkOutput({tag, "_mem_addr"},  W'(bus.mem_addr),  '0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata,     '0);
    checkOutput({tag, "_if_rvalid"}, W'(bus.if_rvalid), '0);
    checkOutput({tag, "_d_rvalid"},  W'(bus.d_rvalid),  '0);
    checkOutput({tag, "_if_rdata"},  bus.if_rdata,      '0);
    checkOutput({tag, "_d_rdata"},   bus.d_rdata,       '0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    checkAllZero("rst");
    reset = 1'b0;

    $display("[TB] single fetch");
    applyStimulus(1'b1, 12'h005, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("f_if_gnt",   W'(bus.if_gnt),   32'd1);
    checkOutput("f_mem_en",   W'(bus.mem_en),   32'd1);
    checkOutput("f_mem_addr", W'(bus.mem_addr), 32'h005);
    checkOutput("f_mem_we",   W'(bus.mem_we),   32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("f_if_rvalid", W'(bus.if_rvalid), 32'd1);
    checkOutput("f_if_rdata",  bus.if_rdata,      32'h2000_1003);
    tick();
    checkOutput("f_rvalid_low", W'(bus.if_rvalid), 32'd0);
    checkOutput("f_rdata_hold", bus.if_rdata,      32'h2000_1003);

    $display("[TB] store and read back");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 12'h0A0, 32'h0000_00FF);
    tick();
    checkOutput("s_d_gnt",     W'(bus.d_gnt),     32'd1);
    checkOutput("s_mem_en",    W'(bus.mem_en),    32'd1);
    checkOutput("s_mem_we",    W'(bus.mem_we),    32'd1);
    checkOutput("s_mem_addr",  W'(bus.mem_addr),  32'h0A0);
    checkOutput("s_mem_wdata", bus.mem_wdata,     32'h0000_00FF);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("s_d_rvalid", W'(bus.d_rvalid), 32'd0);
    tick();
    checkOutput("s_mem_en_off", W'(bus.mem_en),   32'd0);
    checkOutput("s_d_rvalid2",  W'(bus.d_rvalid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 12'h0A0, '0);
    tick();
    checkOutput("rb_d_gnt", W'(bus.d_gnt), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("rb_d_rvalid", W'(bus.d_rvalid), 32'd1);
    checkOutput("rb_d_rdata",  bus.d_rdata,      32'h0000_00FF);

    $display("[TB] simultaneous requests, issued from RESP");
    applyStimulus(1'b1, 12'h010, 1'b1, 1'b0, 12'h0A0, '0);
    tick();
    checkOutput("sim_d_gnt",  W'(bus.d_gnt),  32'd1);
    checkOutput("sim_if_gnt", W'(bus.if_gnt), 32'd0);
    applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("sim_d_rdata", bus.d_rdata, 32'h0000_00FF);
    tick();
    checkOutput("sim_if_gnt2",   W'(bus.if_gnt),   32'd1);
    checkOutput("sim_mem_addr2", W'(bus.mem_addr), 32'h010);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("sim_if_rdata", bus.if_rdata, 32'hA5A5_0010);
    tick();

    $display("[TB] fetch starvation");
    applyStimulus(1'b1, 12'h030, 1'b1, 1'b0, 12'h020, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("stv_d_gnt%0d", k),  W'(bus.d_gnt),  W'(k < 4));
      checkOutput($sformatf("stv_if_gnt%0d", k), W'(bus.if_gnt), W'(k == 4));
      tick();
    end
    checkOutput("stv_if_rdata", bus.if_rdata, 32'hA5A5_0030);
    tick();
    checkOutput("stv_after_d_gnt",  W'(bus.d_gnt),  32'd1);
    checkOutput("stv_after_if_gnt", W'(bus.if_gnt), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();

    $display("[TB] reset during a read access");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 12'h0A0, '0);
    tick();
    checkOutput("mr_d_gnt", W'(bus.d_gnt), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2 reset = 1'b1;
    #1 checkAllZero("mr");
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) begin
      tick();
      checkOutput("mr_no_rvalid", W'(bus.d_rvalid), 32'd0);
    end
    applyStimulus(1'b1, 12'h005, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("mr_if_gnt", W'(bus.if_gnt), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("mr_if_rvalid", W'(bus.if_rvalid), 32'd1);
    checkOutput("mr_if_rdata",  bus.if_rdata,      32'h2000_1003);
    tick();

    $display("[TB] idle");
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("idle_mem_en",    W'(bus.mem_en),    32'd0);
      checkOutput("idle_if_gnt",    W'(bus.if_gnt),    32'd0);
      checkOutput("idle_d_gnt",     W'(bus.d_gnt),     32'd0);
      checkOutput("idle_if_rvalid", W'(bus.if_rvalid), 32'd0);
      checkOutput("idle_d_rvalid",  W'(bus.d_rvalid),  32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
